decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 163 ++++++++++++++++
 tb/tb_decode_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I decode stage: one-entry output register, combinational register-file index/strobe.
// Optional RV32M (MUL/DIV) decoding is enabled by defining DECODE_RV32M_EN.
module decode_stage #(
    parameter logic ILLEGAL_TRAP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic [4:0]  rs1_out,
    output logic [4:0]  rs2_out,
    output logic        rs_read_n,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [4:0]  out_rd,
    output logic        out_rd_write_n,
    output logic [31:0] out_imm,
    output logic [3:0]  out_class,
    output logic [2:0]  out_funct3,
    output logic        out_funct7b5,
    output logic        out_illegal
);

    typedef enum logic [1:0] {S_EMPTY, S_FULL, S_TRAP} state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [3:0] CL_LUI    = 4'd0;
    localparam logic [3:0] CL_AUIPC  = 4'd1;
    localparam logic [3:0] CL_JAL    = 4'd2;
    localparam logic [3:0] CL_JALR   = 4'd3;
    localparam logic [3:0] CL_BRANCH = 4'd4;
    localparam logic [3:0] CL_LOAD   = 4'd5;
    localparam logic [3:0] CL_STORE  = 4'd6;
    localparam logic [3:0] CL_OPIMM  = 4'd7;
    localparam logic [3:0] CL_OP     = 4'd8;
    localparam logic [3:0] CL_FENCE  = 4'd9;
    localparam logic [3:0] CL_SYSTEM = 4'd10;
    localparam logic [3:0] CL_MULDIV = 4'd11;
    localparam logic [3:0] CL_NONE   = 4'd15;

    state_t      state, state_nxt;
    logic        accept;
    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [3:0]  d_class;
    logic [31:0] d_imm;
    logic        d_writes;
    logic        d_illegal;
    logic        d_rd_write_n;

    assign opcode  = in_instr[6:0];
    assign funct7  = in_instr[31:25];
    assign rd      = in_instr[11:7];
    assign rs1_out = in_instr[19:15];
    assign rs2_out = in_instr[24:20];

    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                    in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'b0};
    assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                    in_instr[30:21], 1'b0};

    always_comb begin
        d_class  = CL_NONE;
        d_imm    = 32'd0;
        d_writes = 1'b0;
        case (opcode)
            OPC_LUI:    begin d_class = CL_LUI;    d_imm = imm_u; d_writes = 1'b1; end
            OPC_AUIPC:  begin d_class = CL_AUIPC;  d_imm = imm_u; d_writes = 1'b1; end
            OPC_JAL:    begin d_class = CL_JAL;    d_imm = imm_j; d_writes = 1'b1; end
            OPC_JALR:   begin d_class = CL_JALR;   d_imm = imm_i; d_writes = 1'b1; end
            OPC_BRANCH: begin d_class = CL_BRANCH; d_imm = imm_b; end
            OPC_LOAD:   begin d_class = CL_LOAD;   d_imm = imm_i; d_writes = 1'b1; end
            OPC_STORE:  begin d_class = CL_STORE;  d_imm = imm_s; end
            OPC_OPIMM:  begin d_class = CL_OPIMM;  d_imm = imm_i; d_writes = 1'b1; end
            OPC_FENCE:  begin d_class = CL_FENCE; end
            OPC_SYSTEM: begin d_class = CL_SYSTEM; d_imm = imm_i; end
            OPC_OP: begin
                if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
                    d_class  = CL_OP;
                    d_writes = 1'b1;
                end
`ifdef DECODE_RV32M_EN
                else if (funct7 == 7'b0000001) begin
                    d_class  = CL_MULDIV;
                    d_writes = 1'b1;
                end
`endif
            end
            // Unlisted opcodes and any opcode with [1:0] != 2'b11 land here.
            default: ;
        endcase
    end

    assign d_illegal    = (d_class == CL_NONE);
    assign d_rd_write_n = !(d_writes && (rd != 5'd0));

    assign in_ready  = !rst && !flush &&
                       ((state == S_EMPTY) || ((state == S_FULL) && out_ready));
    assign accept    = in_valid && in_ready;
    assign rs_read_n = !accept;
    assign out_valid = (state != S_EMPTY);

    always_comb begin
        state_nxt = state;
        case (state)
            S_EMPTY: if (accept) state_nxt = (ILLEGAL_TRAP && d_illegal) ? S_TRAP : S_FULL;
            S_FULL: begin
                if (accept)         state_nxt = (ILLEGAL_TRAP && d_illegal) ? S_TRAP : S_FULL;
                else if (out_ready) state_nxt = S_EMPTY;
            end
            S_TRAP:  state_nxt = S_TRAP;
            default: state_nxt = S_EMPTY;
        endcase
        if (flush) state_nxt = S_EMPTY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_EMPTY;
            out_pc         <= 32'd0;
            out_rd         <= 5'd0;
            out_rd_write_n <= 1'b1;
            out_imm        <= 32'd0;
            out_class      <= CL_NONE;
            out_funct3     <= 3'd0;
            out_funct7b5   <= 1'b0;
            out_illegal    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                out_pc         <= in_pc;
                out_rd         <= rd;
                out_rd_write_n <= d_rd_write_n;
                out_imm        <= d_imm;
                out_class      <= d_class;
                out_funct3     <= in_instr[14:12];
                out_funct7b5   <= in_instr[30];
                out_illegal    <= d_illegal;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with hand-computed decode results and handshake checks.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic        in_ready, rs_read_n, out_valid, out_rd_write_n, out_funct7b5, out_illegal;
    logic [31:0] in_instr, in_pc, out_pc, out_imm;
    logic [4:0]  rs1_out, rs2_out, out_rd;
    logic [3:0]  out_class;
    logic [2:0]  out_funct3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .rs1_out(rs1_out), .rs2_out(rs2_out), .rs_read_n(rs_read_n),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_rd(out_rd),
        .out_rd_write_n(out_rd_write_n), .out_imm(out_imm), .out_class(out_class),
        .out_funct3(out_funct3), .out_funct7b5(out_funct7b5), .out_illegal(out_illegal)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = 32'h0; in_pc = 32'h0;
        step();
        step();
        offer(32'hFFF08293, 32'h100);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_rs_read_n", rs_read_n, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_class", out_class, 15);
        chk("rst_wn", out_rd_write_n, 1);
        chk("rst_imm", out_imm, 0);
        chk("rst_pc", out_pc, 0);

        // ADDI x5,x1,-1
        rst = 1'b0;
        #1;
        chk("addi_rs1", rs1_out, 1);
        chk("addi_rs_read_n", rs_read_n, 0);
        chk("addi_in_ready", in_ready, 1);
        step();
        chk("addi_valid", out_valid, 1);
        chk("addi_rd", out_rd, 5);
        chk("addi_imm", out_imm, 32'hFFFFFFFF);
        chk("addi_class", out_class, 7);
        chk("addi_wn", out_rd_write_n, 0);
        chk("addi_pc", out_pc, 32'h100);

        // SW x2,8(x3)
        offer(32'h0021A423, 32'h104);
        #1;
        chk("sw_rs1", rs1_out, 3);
        chk("sw_rs2", rs2_out, 2);
        step();
        chk("sw_imm", out_imm, 8);
        chk("sw_class", out_class, 6);
        chk("sw_wn", out_rd_write_n, 1);
        chk("sw_funct3", out_funct3, 2);

        // MUL x1,x2,x3
        offer(32'h023100B3, 32'h108);
        step();
        in_valid = 1'b0;
`ifdef DECODE_RV32M_EN
        chk("mul_class", out_class, 11);
        chk("mul_illegal", out_illegal, 0);
        chk("mul_wn", out_rd_write_n, 0);
`else
        chk("mul_class", out_class, 15);
        chk("mul_illegal", out_illegal, 1);
        chk("mul_wn", out_rd_write_n, 1);
`endif
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("mul_flush_valid", out_valid, 0);

        // All-zero word traps until flushed
        offer(32'h00000000, 32'h200);
        step();
        chk("zero_illegal", out_illegal, 1);
        chk("zero_class", out_class, 15);
        offer(32'hFFF08293, 32'h204);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("trap_in_ready", in_ready, 0);
            chk("trap_valid", out_valid, 1);
            step();
        end
        in_valid = 1'b0;
        flush = 1'b1;
        #1;
        chk("trap_flush_rs_read_n", rs_read_n, 1);
        step();
        flush = 1'b0;
        chk("trap_flush_valid", out_valid, 0);

        // LUI x7,0x12345
        offer(32'h123453B7, 32'h300);
        step();
        chk("lui_imm", out_imm, 32'h12345000);
        chk("lui_class", out_class, 0);
        chk("lui_rd", out_rd, 7);
        chk("lui_wn", out_rd_write_n, 0);
        // BEQ x0,x0,-4
        offer(32'hFE000EE3, 32'h304);
        step();
        chk("beq_imm", out_imm, 32'hFFFFFFFC);
        chk("beq_class", out_class, 4);
        chk("beq_wn", out_rd_write_n, 1);
        // JAL x0,8: rd=x0 suppresses writeback
        offer(32'h0080006F, 32'h308);
        step();
        chk("jal_imm", out_imm, 8);
        chk("jal_class", out_class, 2);
        chk("jal_wn", out_rd_write_n, 1);
        // SUB x1,x2,x3
        offer(32'h403100B3, 32'h30C);
        step();
        chk("sub_class", out_class, 8);
        chk("sub_f7b5", out_funct7b5, 1);
        chk("sub_imm", out_imm, 0);
        chk("sub_wn", out_rd_write_n, 0);
        // OP with funct7=0000010 is never legal
        offer(32'h043100B3, 32'h310);
        step();
        in_valid = 1'b0;
        chk("badf7_illegal", out_illegal, 1);
        chk("badf7_class", out_class, 15);
        flush = 1'b1;
        step();
        flush = 1'b0;

        // Back-to-back under backpressure
        out_ready = 1'b0;
        offer(32'h123453B7, 32'h400);
        step();
        offer(32'h403100B3, 32'h404);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_in_ready", in_ready, 0);
            chk("stall_pc", out_pc, 32'h400);
            chk("stall_rd", out_rd, 7);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("drain_a_valid", out_valid, 1);
        chk("drain_a_pc", out_pc, 32'h400);
        chk("drain_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("drain_b_valid", out_valid, 1);
        chk("drain_b_pc", out_pc, 32'h404);
        chk("drain_b_class", out_class, 8);
        step();
        chk("drain_empty", out_valid, 0);

        // Flush beats a same-cycle accept
        offer(32'hFFF08293, 32'h500);
        step();
        offer(32'h0021A423, 32'h504);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", in_ready, 0);
        chk("flush_rs_read_n", rs_read_n, 1);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", out_valid, 0);
        chk("flush_pc_kept", out_pc, 32'h500);

        // Reset mid-operation, asserted together with flush
        offer(32'hFFF08293, 32'h600);
        step();
        rst = 1'b1;
        flush = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_rs_read_n", rs_read_n, 1);
        step();
        chk("midrst_valid", out_valid, 0);
        chk("midrst_class", out_class, 15);
        chk("midrst_pc", out_pc, 0);
        rst = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
